// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide-capable EX-stage ALU:
// operation codes and the control FSM state encoding.
package mdu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative radix-2 datapath shared by multiply and divide. Operates on
// unsigned magnitudes; the caller handles signs. One step per cycle for
// WIDTH cycles. done/hi/lo are the combinational result of the final step,
// so the caller can capture them on the same edge that completes the step.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             div_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] nxt_acc_s;
  logic [WIDTH-1:0] nxt_lo_s;
  logic             last_s;

  assign last_s = (cnt_r == CNT_W'(WIDTH - 1));
  assign done   = busy_r && last_s;
  assign hi     = nxt_acc_s;
  assign lo     = nxt_lo_s;

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    sum_s     = {1'b0, acc_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    shift_s   = {acc_r, lo_r[WIDTH-1]};
    ge_s      = (shift_s >= {1'b0, b_r});
    diff_s    = shift_s[WIDTH-1:0] - b_r;
    nxt_acc_s = acc_r;
    nxt_lo_s  = lo_r;
    if (div_r) begin
      if (ge_s) begin
        nxt_acc_s = diff_s;
        nxt_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc_s = shift_s[WIDTH-1:0];
        nxt_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_acc_s = sum_s[WIDTH:1];
      nxt_lo_s  = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Load operands on start, otherwise advance one step per cycle while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      div_r  <= 1'b0;
    end else if (start) begin
      acc_r  <= {WIDTH{1'b0}};
      lo_r   <= a_mag;
      b_r    <= b_mag;
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b1;
      div_r  <= is_div;
    end else if (busy_r) begin
      acc_r <= nxt_acc_s;
      lo_r  <= nxt_lo_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_alu.sv
// EX-stage ALU with valid/ready handshake. Single-cycle logic/arith/compare
// ops complete one cycle after accept; MUL/DIV run on the iterative core and
// stall the pipeline until the result is drained.
module mdu_alu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ov,
  output logic             div0
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_e state_r, state_nxt_s;

  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] res_lo_r, res_hi_r;
  logic             zero_r, ov_r, div0_r;

  // Operation context latched at accept for the iterative ops
  logic             div_r, neg_q_r, neg_rem_r, div_zero_r, ovf_r;
  logic [WIDTH-1:0] a_r;

  logic             hs_s, is_iter_s, is_div_op_s, signed_op_s, div_zero_s, min_neg1_s;
  logic [WIDTH-1:0] add_s, sub_s, sc_lo_s, a_mag_s, b_mag_s;
  logic             sc_ov_s, core_start_s, core_done_s;
  logic [WIDTH-1:0] core_hi_s, core_lo_s, fix_hi_s, fix_lo_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result_lo = res_lo_r;
  assign result_hi = res_hi_r;
  assign zero      = zero_r;
  assign ov        = ov_r;
  assign div0      = div0_r;

  assign hs_s        = in_valid && in_ready_r;
  assign is_iter_s   = (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div_op_s = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op_s = (op == OP_MUL) || (op == OP_DIV);
  assign div_zero_s  = is_div_op_s && (in2 == {WIDTH{1'b0}});
  assign min_neg1_s  = (op == OP_DIV) && (in1 == MIN_VAL) && (in2 == ALL_ONES);
  assign a_mag_s     = (signed_op_s && in1[WIDTH-1]) ? -in1 : in1;
  assign b_mag_s     = (signed_op_s && in2[WIDTH-1]) ? -in2 : in2;
  assign add_s       = in1 + in2;
  assign sub_s       = in1 - in2;
  // Divide by zero bypasses the core entirely; its result is fixed
  assign core_start_s = (state_r == IDLE) && hs_s && is_iter_s && !div_zero_s;

  mdu_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start_s),
    .is_div (is_div_op_s),
    .a_mag  (a_mag_s),
    .b_mag  (b_mag_s),
    .done   (core_done_s),
    .hi     (core_hi_s),
    .lo     (core_lo_s)
  );

  // Single-cycle operation results and signed overflow
  always_comb begin
    sc_lo_s = {WIDTH{1'b0}};
    sc_ov_s = 1'b0;
    case (op)
      OP_AND:  sc_lo_s = in1 & in2;
      OP_OR:   sc_lo_s = in1 | in2;
      OP_ADD: begin
        sc_lo_s = add_s;
        sc_ov_s = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_s[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_XOR:  sc_lo_s = in1 ^ in2;
      OP_NOR:  sc_lo_s = ~(in1 | in2);
      OP_SUB: begin
        sc_lo_s = sub_s;
        sc_ov_s = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_s[WIDTH-1] == in2[WIDTH-1]);
      end
      OP_SLT:  sc_lo_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: sc_lo_s = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default: sc_lo_s = {WIDTH{1'b0}};
    endcase
  end

  // Sign fix-up of the core's magnitude result on the final step
  always_comb begin
    prod_fix_s = {core_hi_s, core_lo_s};
    fix_hi_s   = core_hi_s;
    fix_lo_s   = core_lo_s;
    if (div_r) begin
      fix_lo_s = neg_q_r   ? -core_lo_s : core_lo_s;
      fix_hi_s = neg_rem_r ? -core_hi_s : core_hi_s;
    end else begin
      prod_fix_s = neg_q_r ? -{core_hi_s, core_lo_s} : {core_hi_s, core_lo_s};
      fix_hi_s   = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s   = prod_fix_s[WIDTH-1:0];
    end
  end

  // Control FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Control FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_nxt_s = is_iter_s ? BUSY : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (div_zero_r || core_done_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result/flag registers and handshake outputs; only written entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res_lo_r    <= {WIDTH{1'b0}};
      res_hi_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ov_r        <= 1'b0;
      div0_r      <= 1'b0;
      div_r       <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      ovf_r       <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            in_ready_r <= 1'b0;
            if (is_iter_s) begin
              div_r      <= is_div_op_s;
              neg_q_r    <= signed_op_s && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_rem_r  <= signed_op_s && in1[WIDTH-1];
              div_zero_r <= div_zero_s;
              ovf_r      <= min_neg1_s;
              a_r        <= in1;
            end else begin
              out_valid_r <= 1'b1;
              res_lo_r    <= sc_lo_s;
              res_hi_r    <= {WIDTH{1'b0}};
              zero_r      <= (sc_lo_s == {WIDTH{1'b0}});
              ov_r        <= sc_ov_s;
              div0_r      <= 1'b0;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          if (div_zero_r) begin
            out_valid_r <= 1'b1;
            res_lo_r    <= ALL_ONES;
            res_hi_r    <= a_r;
            zero_r      <= 1'b0;
            ov_r        <= 1'b0;
            div0_r      <= 1'b1;
          end else if (core_done_s) begin
            out_valid_r <= 1'b1;
            res_lo_r    <= fix_lo_s;
            res_hi_r    <= fix_hi_s;
            zero_r      <= (fix_lo_s == {WIDTH{1'b0}});
            ov_r        <= ovf_r;
            div0_r      <= 1'b0;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_alu.sv
// Directed self-checking bench for mdu_alu (WIDTH=32).
module tb_mdu_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result_lo, result_hi;
  logic        zero, ov, div0;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] held_lo;

  always #5 clk = ~clk;

  mdu_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .zero      (zero),
    .ov        (ov),
    .div0      (div0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request, then count cycles from the accept edge to out_valid
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l);
    @(negedge clk);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_lo", {32'd0, result_lo}, 64'd0);
    chk("rst_flags", {61'd0, zero, ov, div0}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);

    // ADD with signed overflow
    run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_lo", {32'd0, result_lo}, 64'h8000_0000);
    chk("add_hi", {32'd0, result_hi}, 64'd0);
    chk("add_flags", {61'd0, zero, ov, div0}, 64'b010);
    drain();

    // SUB to zero
    run_op(4'd6, 32'd5, 32'd5, lat);
    chk("sub_lo", {32'd0, result_lo}, 64'd0);
    chk("sub_flags", {61'd0, zero, ov, div0}, 64'b100);
    drain();

    // SUB overflow: MIN - 1
    run_op(4'd6, 32'h8000_0000, 32'd1, lat);
    chk("subov_lo", {32'd0, result_lo}, 64'h7FFF_FFFF);
    chk("subov_ov", {63'd0, ov}, 64'd1);
    drain();

    // Compares
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_lo", {32'd0, result_lo}, 64'd1);
    drain();
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, lat);
    chk("sltu_lo", {32'd0, result_lo}, 64'd0);
    chk("sltu_zero", {63'd0, zero}, 64'd1);
    drain();

    // Logic ops
    run_op(4'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat);
    chk("xor_lo", {32'd0, result_lo}, 64'hFFFF_FFFF);
    drain();
    run_op(4'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat);
    chk("nor_lo", {32'd0, result_lo}, 64'd0);
    chk("nor_zero", {63'd0, zero}, 64'd1);
    drain();
    run_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    chk("and_lo", {32'd0, result_lo}, 64'hF000_F000);
    drain();
    run_op(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    chk("or_lo", {32'd0, result_lo}, 64'hFFF0_FFF0);
    drain();

    // Unused op codes
    run_op(4'd5, 32'h1234_5678, 32'h1111_1111, lat);
    chk("op5_lo", {32'd0, result_lo}, 64'd0);
    chk("op5_zero", {63'd0, zero}, 64'd1);
    drain();
    run_op(4'd13, 32'h1234_5678, 32'h1111_1111, lat);
    chk("op13_lo", {32'd0, result_lo}, 64'd0);
    chk("op13_lat", 64'(lat), 64'd1);
    drain();

    // Signed multiply
    run_op(4'd9, 32'hFFFF_FFFD, 32'd7, lat);
    chk("mul_lat", 64'(lat), 64'd33);
    chk("mul_res", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_ov", {63'd0, ov}, 64'd0);
    drain();

    // Unsigned multiply
    run_op(4'd10, 32'hFFFF_FFFF, 32'd2, lat);
    chk("mulu_res", {result_hi, result_lo}, 64'h0000_0001_FFFF_FFFE);
    drain();

    // Signed divide with negative dividend
    run_op(4'd11, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_lo", {32'd0, result_lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, result_hi}, 64'hFFFF_FFFF);
    drain();

    // Unsigned divide by zero
    run_op(4'd12, 32'd100, 32'd0, lat);
    chk("div0_lat", 64'(lat), 64'd2);
    chk("div0_lo", {32'd0, result_lo}, 64'hFFFF_FFFF);
    chk("div0_hi", {32'd0, result_hi}, 64'd100);
    chk("div0_flag", {63'd0, div0}, 64'd1);
    drain();

    // Signed MIN / -1
    run_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("minov_lat", 64'(lat), 64'd33);
    chk("minov_lo", {32'd0, result_lo}, 64'h8000_0000);
    chk("minov_hi", {32'd0, result_hi}, 64'd0);
    chk("minov_ov", {63'd0, ov}, 64'd1);
    drain();

    // Unsigned divide, then backpressure in DONE with new requests pending
    run_op(4'd12, 32'd100, 32'd7, lat);
    chk("divu_lo", {32'd0, result_lo}, 64'd14);
    chk("divu_hi", {32'd0, result_hi}, 64'd2);
    held_lo = result_lo;
    @(negedge clk);
    in_valid = 1'b1; op = 4'd2; in1 = 32'd1; in2 = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_lo", {32'd0, result_lo}, {32'd0, held_lo});
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    op = 4'd11; in1 = 32'hFFFF_FFF9; in2 = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_lo", {32'd0, result_lo}, 64'd0);
    chk("arst_hi", {32'd0, result_hi}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("arst_ready", {63'd0, in_ready}, 64'd1);
    run_op(4'd2, 32'd2, 32'd3, lat);
    chk("post_add_lat", 64'(lat), 64'd1);
    chk("post_add_lo", {32'd0, result_lo}, 64'd5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_alu.md
Name: mdu_alu

Overview:
- Parametrised, handshaked successor to the single-cycle 32-bit datapath ALU.
- Adds signed/unsigned compare, XOR/NOR and an iterative multiply/divide unit with HI/LO results.
- Sits in the EX stage. Single-cycle ops return in 1 cycle; MUL/DIV stall the pipeline through valid/ready until done.
- One clock domain.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk        in   1        rising-edge clock
- rst_n      in   1        asynchronous active-low reset
- in_valid   in   1        operation request
- in_ready   out  1        block can accept a request
- op         in   4        operation code (see Behaviour)
- in1        in   WIDTH    operand A
- in2        in   WIDTH    operand B
- out_valid  out  1        result valid
- out_ready  in   1        consumer accepts result
- result_lo  out  WIDTH    result / LO (product low, quotient)
- result_hi  out  WIDTH    HI (product high, remainder); 0 for single-cycle ops
- zero       out  1        result_lo == 0
- ov         out  1        signed overflow (ADD/SUB/DIV)
- div0       out  1        divide by zero

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. rst_n low immediately forces state IDLE and clears all outputs and internal regs to 0: out_valid=0, result_lo/hi=0, zero/ov/div0=0. in_ready=1 after release. Reset mid-operation aborts it with no result.
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT signed, 8 SLTU.
  - 9 MUL signed, 10 MULU, 11 DIV signed, 12 DIVU.
  - Other codes (5, 13–15) complete as single-cycle with result 0 and zero=1.
- FSM states:
  - IDLE: in_ready=1. A handshake is in_valid&&in_ready. A single-cycle op -> DONE, with outputs registered at the next edge (latency 1). A MUL/DIV op latches operands -> BUSY.
  - BUSY: in_ready=0. One radix-2 step per cycle for exactly WIDTH cycles (counter 0..WIDTH-1), then sign fix-up at the last edge -> DONE. Latency from accept to out_valid is WIDTH+1 cycles.
  - DONE: out_valid=1, in_ready=0, outputs held stable. out_ready=1 -> IDLE next edge, out_valid drops. No back-to-back accept in the same cycle as drain.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ADD ov = operand signs equal && result sign differs.
  - SUB ov = operand signs differ && result sign == in2 sign.
  - ov=0 for all other single-cycle ops and for MUL.
  - SLT/SLTU: result_lo = 1 or 0.
  - MUL: full 2*WIDTH product; {result_hi,result_lo}. Signed MUL uses magnitudes plus final negate when sign(in1)^sign(in2).
  - DIV: restoring division on magnitudes. Quotient sign = sign(in1)^sign(in2); remainder sign = sign(in1).
- Division boundary cases:
  - in2==0: skip iteration (BUSY exit after 1 cycle, latency 2). result_lo = all ones, result_hi = in1, div0=1.
  - Signed DIV of MIN by -1: result_lo=MIN, result_hi=0, ov=1. Runs full latency.
- Flags: zero reflects result_lo only, for every op. Flags update only on transition into DONE.
- in1/in2/op changes while BUSY or DONE are ignored.

Decomposition:
- Package mdu_pkg: op-code localparams (OP_AND..OP_DIVU), state enum encoding (IDLE/BUSY/DONE).
- One sub-module: mdu_iter_core. Holds the shift/accumulate datapath for MUL/DIV: start, is_div, operand magnitudes in; done, hi/lo out.
- The top holds the FSM, single-cycle ops, sign handling and flags.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> out_valid 1 cycle after accept, result_lo=0x80000000, ov=1, zero=0. SUB 5-5 -> result_lo=0, zero=1, ov=0.
- SLT 0xFFFFFFFF vs 1 -> result_lo=1; SLTU same operands -> 0. XOR/NOR 0xF0F0F0F0,0x0F0F0F0F -> 0xFFFFFFFF / 0.
- MUL -3 * 7 -> out_valid exactly 33 cycles after accept, {hi,lo}=0xFFFFFFFF_FFFFFFEB. MULU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, div0=1, latency 2. DIV 0x80000000/-1 -> lo=0x80000000, ov=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid requests not accepted. out_ready=1 -> IDLE next cycle.
- Assert rst_n low mid-DIV (cycle 10) -> out_valid=0 and outputs 0 immediately (asynchronous). After release, a new ADD 2+3 -> result_lo=5.
